// File: rtl/mips_pkg.sv
// Shared types and field layout for the single-cycle core's
// instruction format and the imem programmer.
package mips_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_W    = 3;
  localparam int REG_W   = 3;
  localparam int IMM_W   = 7;

  localparam int OP_LSB  = 13;
  localparam int RA_LSB  = 10;
  localparam int RB_LSB  = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_STORE = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_BEQ   = 3'b101,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_OVERFLOW = 2'b10
  } err_code_t;

  typedef logic [1:0] prog_state_t;

  localparam prog_state_t S_IDLE = 2'd0;
  localparam prog_state_t S_LOAD = 2'd1;
  localparam prog_state_t S_DONE = 2'd2;
  localparam prog_state_t S_ERR  = 2'd3;

endpackage

// File: rtl/imem_programmer_if.sv
// Field-level instruction request channel with
// a valid/ready handshake.
interface imem_programmer_if;
  import mips_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [REG_W-1:0] in_ra;
  logic [REG_W-1:0] in_rb;
  logic [IMM_W-1:0] in_imm;

  modport master (
    output in_valid,
    output in_op,
    output in_ra,
    output in_rb,
    output in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_ra,
    input  in_rb,
    input  in_imm,
    output in_ready
  );

endinterface

// File: rtl/instr_encoder.sv
// Packs request fields into an instruction word
// and flags opcodes outside the ISA.
module instr_encoder
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   ra,
  input  logic [REG_W-1:0]   rb,
  input  logic [IMM_W-1:0]   imm,
  output logic [INSTR_W-1:0] word,
  output logic               legal
);

  assign word = {op, ra, rb, imm};

  always_comb begin
    legal = 1'b0;
    unique case (op)
      OP_STORE,
      OP_LOAD,
      OP_ADD,
      OP_BEQ,
      OP_HALT: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_programmer.sv
// Loads a program into instruction memory from a
// request stream; stops on HALT, bad opcode or overflow.
module imem_programmer
  import mips_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  imem_programmer_if.slave   req,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [ADDR_W:0]    instr_count
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  prog_state_t        state;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [INSTR_W-1:0] word;
  logic               legal;
  logic               accept;
  logic               is_halt;

  instr_encoder u_enc (
    .op    (req.in_op),
    .ra    (req.in_ra),
    .rb    (req.in_rb),
    .imm   (req.in_imm),
    .word  (word),
    .legal (legal)
  );

  assign busy         = (state == S_LOAD);
  assign req.in_ready = (state == S_LOAD);
  assign accept       = req.in_valid && busy;
  assign is_halt      = (req.in_op == OP_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      instr_count <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state       <= S_LOAD;
            wr_ptr      <= '0;
            instr_count <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
          end
        end
        S_LOAD: begin
          if (accept && !legal) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_ILLEGAL;
          end else if (accept) begin
            imem_we     <= 1'b1;
            imem_addr   <= wr_ptr;
            imem_wdata  <= word;
            wr_ptr      <= wr_ptr + 1'b1;
            instr_count <= instr_count + 1'b1;
            // HALT wins over overflow in the last slot
            if (is_halt) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (wr_ptr == LAST) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_OVERFLOW;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_programmer.sv
// Directed bench for imem_programmer with a
// 4-word memory to reach the overflow boundary.
module tb_imem_programmer;
  import mips_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic               clk;
  logic               reset;
  logic               start;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         err_code;
  logic [ADDR_W:0]    instr_count;

  int checks = 0;
  int errors = 0;

  imem_programmer_if bus ();

  imem_programmer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .req         (bus.slave),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [2:0] ra,
                      input logic [2:0] rb,
                      input logic [6:0] imm,
                      input logic       we,
                      input int         addr,
                      input logic [15:0] wd);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_ra    = ra;
    bus.in_rb    = rb;
    bus.in_imm   = imm;
    tick();
    bus.in_valid = 1'b0;
    check("we", 32'(imem_we), 32'(we));
    check("addr", 32'(imem_addr), 32'(addr));
    check("wdata", 32'(imem_wdata), 32'(wd));
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_ra    = '0;
    bus.in_rb    = '0;
    bus.in_imm   = '0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_ready", 32'(bus.in_ready), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", 32'(imem_wdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_cnt", 32'(instr_count), 0);

    send(3'b010, 3'd1, 3'd2, 7'd5, 1'b0, 0, 16'h0000);
    check("idle_busy", 32'(busy), 0);
    check("idle_cnt", 32'(instr_count), 0);

    // basic load, with a stray start mid-session
    pulse_start();
    check("ld_ready", 32'(bus.in_ready), 1);
    check("ld_busy", 32'(busy), 1);
    send(3'b010, 3'd1, 3'd2, 7'd5, 1'b1, 0, 16'h4505);
    pulse_start();
    check("ld_start_ign", 32'(instr_count), 1);
    check("ld_nowe", 32'(imem_we), 0);
    send(3'b111, 3'd0, 3'd0, 7'd0, 1'b1, 1, 16'hE000);
    check("ld_done", 32'(done), 1);
    check("ld_err", 32'(err), 0);
    check("ld_busy2", 32'(busy), 0);
    check("ld_ready2", 32'(bus.in_ready), 0);
    check("ld_cnt", 32'(instr_count), 2);
    send(3'b010, 3'd1, 3'd1, 7'd1, 1'b0, 1, 16'hE000);
    check("ld_cnt_hold", 32'(instr_count), 2);

    // restart from DONE
    pulse_start();
    check("rs_done_clr", 32'(done), 0);
    check("rs_cnt_clr", 32'(instr_count), 0);
    send(3'b111, 3'd0, 3'd0, 7'd0, 1'b1, 0, 16'hE000);
    check("rs_done", 32'(done), 1);
    check("rs_cnt", 32'(instr_count), 1);

    // illegal opcode
    pulse_start();
    send(3'b000, 3'd3, 3'd0, 7'h10, 1'b1, 0, 16'h0C10);
    send(3'b011, 3'd0, 3'd0, 7'd0, 1'b0, 0, 16'h0C10);
    check("il_err", 32'(err), 1);
    check("il_code", 32'(err_code), 1);
    check("il_cnt", 32'(instr_count), 1);
    check("il_ready", 32'(bus.in_ready), 0);
    check("il_done", 32'(done), 0);

    // overflow with in_valid held
    pulse_start();
    check("of_code_clr", 32'(err_code), 0);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b001;
    bus.in_rb    = 3'd0;
    for (int i = 0; i < 4; i++) begin
      bus.in_ra  = 3'(i);
      bus.in_imm = 7'(i);
      tick();
      check("of_we", 32'(imem_we), 1);
      check("of_addr", 32'(imem_addr), 32'(i));
      check("of_wdata", 32'(imem_wdata),
            32'(16'h2000 | (i << 10) | i));
    end
    tick();
    bus.in_valid = 1'b0;
    check("of_we_after", 32'(imem_we), 0);
    check("of_err", 32'(err), 1);
    check("of_code", 32'(err_code), 2);
    check("of_cnt", 32'(instr_count), 4);
    check("of_done", 32'(done), 0);

    // HALT in the last slot
    pulse_start();
    send(3'b001, 3'd0, 3'd0, 7'd0, 1'b1, 0, 16'h2000);
    send(3'b101, 3'd1, 3'd2, 7'd1, 1'b1, 1, 16'hA501);
    send(3'b000, 3'd2, 3'd0, 7'd2, 1'b1, 2, 16'h0802);
    send(3'b111, 3'd3, 3'd0, 7'd3, 1'b1, 3, 16'hEC03);
    check("hl_done", 32'(done), 1);
    check("hl_err", 32'(err), 0);
    check("hl_code", 32'(err_code), 0);
    check("hl_cnt", 32'(instr_count), 4);

    // reset in the same cycle as an accept
    pulse_start();
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b010;
    bus.in_ra    = 3'd1;
    bus.in_rb    = 3'd2;
    bus.in_imm   = 7'd5;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("mr_we", 32'(imem_we), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_ready", 32'(bus.in_ready), 0);
    check("mr_addr", 32'(imem_addr), 0);
    check("mr_wdata", 32'(imem_wdata), 0);
    check("mr_cnt", 32'(instr_count), 0);
    check("mr_done", 32'(done), 0);
    send(3'b010, 3'd1, 3'd2, 7'd5, 1'b0, 0, 16'h0000);
    check("mr_idle_cnt", 32'(instr_count), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
